// File: rtl/pipe_delay_pkg.sv
// Shared constants for the credit-based receive end of a fixed-latency delay pipe.
package pipe_delay_pkg;
   localparam int DEF_NBITS = 8;
   localparam int DEF_LAT   = 3;

   function automatic int credit_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/pipe_delay_rx_queue.sv
// Circular landing queue for words leaving the delay pipe; writes while full are dropped and flagged.
module pipe_delay_rx_queue
   import pipe_delay_pkg::*;
#(
   parameter int NBITS = DEF_NBITS,
   parameter int DEPTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_enq,
   input  logic [NBITS-1:0] i_data,
   input  logic             i_deq,
   output logic [NBITS-1:0] o_data,
   output logic             o_empty,
   output logic             o_full,
   output logic             o_overflow
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = credit_w(DEPTH);

   logic [NBITS-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr, r_rptr;
   logic [CW-1:0]    r_count;
   logic             r_overflow;
   logic             w_enq, w_deq;

   assign o_full     = (r_count == CW'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign w_enq      = i_enq && !o_full;
   assign w_deq      = i_deq && !o_empty;
   assign o_data     = r_mem[r_rptr];
   assign o_overflow = r_overflow;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_enq) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= inc_ptr(r_wptr);
         end
         if (w_deq) r_rptr <= inc_ptr(r_rptr);
         if (w_enq && !w_deq)      r_count <= r_count + CW'(1);
         else if (!w_enq && w_deq) r_count <= r_count - CW'(1);
         if (i_enq && o_full) r_overflow <= 1'b1;
      end
   end
endmodule

// File: rtl/pipe_delay_credit_rx.sv
// Credit issuer plus landing queue: the sender may inject only while credits remain,
// so the non-stallable pipe can never deliver more words than the queue has room for.
module pipe_delay_credit_rx
   import pipe_delay_pkg::*;
#(
   parameter int NBITS = DEF_NBITS,
   parameter int DEPTH = 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       send_val,
   output logic                       send_rdy,
   input  logic                       in_val,
   input  logic [NBITS-1:0]           in_,
   output logic                       out_val,
   input  logic                       out_rdy,
   output logic [NBITS-1:0]           out,
   output logic [credit_w(DEPTH)-1:0] credits,
   output logic                       overflow
);
   localparam int CW = credit_w(DEPTH);

   logic [CW-1:0] r_credits;
   logic          w_send, w_deq, w_empty, w_full;

   assign send_rdy = (r_credits != '0);
   assign w_send   = send_val && send_rdy;
   assign out_val  = !w_empty;
   assign w_deq    = out_val && out_rdy;
   assign credits  = r_credits;

   // A credit is spent on send and returned when the word leaves the queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_credits <= CW'(DEPTH);
      end else if (w_send && !w_deq) begin
         r_credits <= r_credits - CW'(1);
      end else if (w_deq && !w_send && r_credits != CW'(DEPTH)) begin
         r_credits <= r_credits + CW'(1);
      end
   end

   pipe_delay_rx_queue #(.NBITS(NBITS), .DEPTH(DEPTH)) u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_enq      (in_val),
      .i_data     (in_),
      .i_deq      (w_deq),
      .o_data     (out),
      .o_empty    (w_empty),
      .o_full     (w_full),
      .o_overflow (overflow)
   );

   logic w_unused;
   assign w_unused = w_full;
endmodule

// File: tb/tb_pipe_delay_credit_rx.sv
// Directed bench: a 3-stage delay pipe feeds the receiver; table vectors plus hand sequences.
module tb_pipe_delay_credit_rx;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       send_val = 1'b0;
   logic [7:0] send_dat = '0;
   logic       send_rdy;
   logic       in_val;
   logic [7:0] in_;
   logic       out_val;
   logic       out_rdy = 1'b0;
   logic [7:0] out;
   logic [2:0] credits;
   logic       overflow;
   logic       frc_val = 1'b0;
   logic [7:0] frc_dat = '0;

   logic [2:0] p_v;
   logic [7:0] p_d [3];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipe_delay_credit_rx #(.NBITS(8), .DEPTH(5)) dut (
      .clk(clk), .rst_n(rst_n), .send_val(send_val), .send_rdy(send_rdy),
      .in_val(in_val), .in_(in_), .out_val(out_val), .out_rdy(out_rdy),
      .out(out), .credits(credits), .overflow(overflow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_v <= '0;
         for (int i = 0; i < 3; i++) p_d[i] <= '0;
      end else begin
         p_v    <= {p_v[1:0], send_val & send_rdy};
         p_d[0] <= send_dat;
         p_d[1] <= p_d[0];
         p_d[2] <= p_d[1];
      end
   end

   assign in_val = p_v[2] | frc_val;
   assign in_    = frc_val ? frc_dat : p_d[2];

   typedef struct {
      logic       sv;
      logic [7:0] d;
      logic       ordy;
      logic       srdy;
      logic       oval;
      logic [7:0] dout;
      logic [2:0] cred;
      logic       ovf;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic sv, input logic [7:0] d, input logic ordy, input logic srdy,
                      input logic oval, input logic [7:0] dout, input logic [2:0] cred);
      vec_t v;
      v.sv = sv; v.d = d; v.ordy = ordy; v.srdy = srdy;
      v.oval = oval; v.dout = dout; v.cred = cred; v.ovf = 1'b0;
      vt.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      logic [7:0] sb[$];
      int         rcv;
      int         idx;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_credits", 32'(credits), 32'd5);
      chk("rst_send_rdy", 32'(send_rdy), 32'd1);
      chk("rst_out_val", 32'(out_val), 32'd0);
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Single word: sent cycle 0, visible cycle 4, credit back cycle 5
      add(1, 8'hA5, 1, 1, 0, 8'h00, 5);
      add(0, 8'h00, 1, 1, 0, 8'h00, 4);
      add(0, 8'h00, 1, 1, 0, 8'h00, 4);
      add(0, 8'h00, 1, 1, 0, 8'h00, 4);
      add(0, 8'h00, 1, 1, 1, 8'hA5, 4);
      add(0, 8'h00, 1, 1, 0, 8'h00, 5);
      // Backpressure: 5 fires then stall, queue fills, then drains in order
      add(1, 8'h10, 0, 1, 0, 8'h00, 5);
      add(1, 8'h11, 0, 1, 0, 8'h00, 4);
      add(1, 8'h12, 0, 1, 0, 8'h00, 3);
      add(1, 8'h13, 0, 1, 0, 8'h00, 2);
      add(1, 8'h14, 0, 1, 1, 8'h10, 1);
      add(1, 8'h15, 0, 0, 1, 8'h10, 0);
      add(1, 8'h16, 0, 0, 1, 8'h10, 0);
      add(1, 8'h17, 0, 0, 1, 8'h10, 0);
      add(0, 8'h00, 1, 0, 1, 8'h10, 0);
      add(0, 8'h00, 1, 1, 1, 8'h11, 1);
      add(0, 8'h00, 1, 1, 1, 8'h12, 2);
      add(0, 8'h00, 1, 1, 1, 8'h13, 3);
      add(0, 8'h00, 1, 1, 1, 8'h14, 4);
      add(0, 8'h00, 1, 1, 0, 8'h00, 5);

      foreach (vt[i]) begin
         @(negedge clk);
         chk($sformatf("vec%0d_send_rdy", i), 32'(send_rdy), 32'(vt[i].srdy));
         chk($sformatf("vec%0d_out_val", i), 32'(out_val), 32'(vt[i].oval));
         if (vt[i].oval) chk($sformatf("vec%0d_out", i), 32'(out), 32'(vt[i].dout));
         chk($sformatf("vec%0d_credits", i), 32'(credits), 32'(vt[i].cred));
         chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vt[i].ovf));
         send_val = vt[i].sv;
         send_dat = vt[i].d;
         out_rdy  = vt[i].ordy;
      end

      // Streaming 0x01..0x20 at full rate
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (t < 32) chk("stream_send_rdy", 32'(send_rdy), 32'd1);
         chk("stream_out_val", 32'(out_val), 32'((t >= 4 && t < 36) ? 1 : 0));
         if (t >= 4 && t < 36) chk("stream_out", 32'(out), 32'(t - 3));
         send_val = (t < 32);
         send_dat = 8'(t + 1);
         out_rdy  = 1'b1;
      end
      send_val = 1'b0;

      // Simultaneous send and dequeue at credits=2
      out_rdy = 1'b0;
      for (int t = 0; t < 3; t++) begin
         send_val = 1'b1; send_dat = 8'h30 + 8'(t);
         @(negedge clk);
      end
      send_val = 1'b0;
      repeat (3) @(negedge clk);
      chk("simul_pre_credits", 32'(credits), 32'd2);
      chk("simul_pre_out_val", 32'(out_val), 32'd1);
      send_val = 1'b1; send_dat = 8'h33; out_rdy = 1'b1;
      @(negedge clk);
      chk("simul_credits", 32'(credits), 32'd2);
      send_val = 1'b0;
      repeat (8) @(negedge clk);
      chk("simul_drain_credits", 32'(credits), 32'd5);
      chk("simul_drain_empty", 32'(out_val), 32'd0);

      // 13 words with irregular out_rdy: order must hold across pointer wraps
      rcv = 0; idx = 0;
      for (int c = 0; c < 200 && rcv < 13; c++) begin
         @(negedge clk);
         out_rdy = (c % 3 != 2);
         if (out_val) begin
            if (sb.size() == 0) chk("wrap_spurious", 32'(out), 32'hFFFF_FFFF);
            else begin
               chk("wrap_data", 32'(out), 32'(sb[0]));
               if (out_rdy) begin
                  void'(sb.pop_front());
                  rcv++;
               end
            end
         end
         send_val = (idx < 13);
         send_dat = 8'h40 + 8'(idx);
         if (send_val && send_rdy) begin
            sb.push_back(send_dat);
            idx++;
         end
      end
      send_val = 1'b0;
      chk("wrap_count", 32'(rcv), 32'd13);
      out_rdy = 1'b1;
      repeat (6) @(negedge clk);
      chk("wrap_credits", 32'(credits), 32'd5);

      // Overflow: fill, force an extra word, queue must be untouched
      out_rdy = 1'b0;
      for (int t = 0; t < 5; t++) begin
         send_val = 1'b1; send_dat = 8'h80 + 8'(t);
         @(negedge clk);
      end
      send_val = 1'b0;
      repeat (6) @(negedge clk);
      chk("ovf_pre_credits", 32'(credits), 32'd0);
      chk("ovf_pre_flag", 32'(overflow), 32'd0);
      chk("ovf_pre_head", 32'(out), 32'h80);
      frc_val = 1'b1; frc_dat = 8'h77;
      @(negedge clk);
      frc_val = 1'b0;
      chk("ovf_set", 32'(overflow), 32'd1);
      repeat (3) @(negedge clk);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      out_rdy = 1'b1;
      for (int t = 0; t < 5; t++) begin
         chk("ovf_drain_val", 32'(out_val), 32'd1);
         chk("ovf_drain_data", 32'(out), 32'h80 + 32'(t));
         @(negedge clk);
      end
      chk("ovf_drain_empty", 32'(out_val), 32'd0);
      chk("ovf_drain_credits", 32'(credits), 32'd5);
      chk("ovf_still_set", 32'(overflow), 32'd1);

      // Reset mid-stream
      out_rdy = 1'b0;
      for (int t = 0; t < 4; t++) begin
         send_val = 1'b1; send_dat = 8'hC0 + 8'(t);
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      chk("mrst_async_credits", 32'(credits), 32'd5);
      chk("mrst_async_out_val", 32'(out_val), 32'd0);
      send_val = 1'b0;
      @(negedge clk);
      chk("mrst_credits", 32'(credits), 32'd5);
      chk("mrst_send_rdy", 32'(send_rdy), 32'd1);
      chk("mrst_out_val", 32'(out_val), 32'd0);
      chk("mrst_overflow", 32'(overflow), 32'd0);
      chk("mrst_out", 32'(out), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("mrst_idle_credits", 32'(credits), 32'd5);
      chk("mrst_idle_out_val", 32'(out_val), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
